// File: rtl/hwpe_ctrl_package.sv
// Shared types and helpers for the HWPE controller sequential radix multiplier.
package hwpe_ctrl_package;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StNeg,
        StDone
    } hwpe_ctrl_seq_mult_state_t;

    function automatic int unsigned hwpe_ctrl_seq_mult_iter(input int unsigned aw,
                                                            input int unsigned rb);
        return (aw + rb - 1) / rb;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_seq_mult_pp.sv
// Combinational partial-product generator: (chunk * b_ext) << (k * RB), modulo 2^PW.
module hwpe_ctrl_seq_mult_pp #(
    parameter int unsigned RB = 2,
    parameter int unsigned PW = 16,
    parameter int unsigned CW = 2
) (
    input  logic [RB-1:0] chunk_i,
    input  logic [PW-1:0] b_ext_i,
    input  logic [CW-1:0] k_i,
    input  logic          last_i,
    input  logic          signed_i,
    output logic [PW-1:0] pp_o
);

    logic [PW-1:0] chunk_ext;
    logic [PW-1:0] prod;

    // Only the top chunk carries the sign of the multiplier.
    always_comb begin
        chunk_ext = {PW{last_i & signed_i & chunk_i[RB-1]}};
        chunk_ext[RB-1:0] = chunk_i;
    end

    assign prod = chunk_ext * b_ext_i;
    assign pp_o = prod << (32'(k_i) * RB);

endmodule

// File: rtl/hwpe_ctrl_seq_mult_radix.sv
// Sequential radix-2^RB multiplier with valid/ready handshakes and optional negation.
// Signed operand support is compiled in with HWPE_CTRL_SEQ_MULT_SIGNED_EN.
module hwpe_ctrl_seq_mult_radix
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned BW = 8,
    parameter int unsigned RB = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [AW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    input  logic             signed_i,
    input  logic             negate_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [AW+BW-1:0] prod_o
);

    localparam int unsigned N   = hwpe_ctrl_seq_mult_iter(AW, RB);
    localparam int unsigned PW  = AW + BW;
    localparam int unsigned AEW = N * RB;
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;

    hwpe_ctrl_seq_mult_state_t state_q;
    logic [AEW-1:0] a_q;
    logic [PW-1:0]  b_q;
    logic [PW-1:0]  acc_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q;

    logic           accept;
    logic           last;
    logic           sgn_acc;
    logic           sgn_run;
    logic [AEW-1:0] a_ext;
    logic [PW-1:0]  b_ext;
    logic [PW-1:0]  pp;

    assign accept = start_i && (state_q == StIdle);
    assign last   = (cnt_q == CW'(N - 1));

`ifdef HWPE_CTRL_SEQ_MULT_SIGNED_EN
    logic sgn_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            sgn_q <= 1'b0;
        end else if (accept) begin
            sgn_q <= signed_i;
        end
    end

    assign sgn_acc = signed_i;
    assign sgn_run = sgn_q;
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign sgn_acc       = 1'b0;
    assign sgn_run       = 1'b0;
`endif

    always_comb begin
        a_ext = {AEW{sgn_acc & a_i[AW-1]}};
        a_ext[AW-1:0] = a_i;
        b_ext = {PW{sgn_acc & b_i[BW-1]}};
        b_ext[BW-1:0] = b_i;
    end

    // a_q shifts right each RUN cycle, so the current chunk is always at the bottom.
    hwpe_ctrl_seq_mult_pp #(
        .RB(RB),
        .PW(PW),
        .CW(CW)
    ) u_pp (
        .chunk_i (a_q[RB-1:0]),
        .b_ext_i (b_q),
        .k_i     (cnt_q),
        .last_i  (last),
        .signed_i(sgn_run),
        .pp_o    (pp)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= a_ext;
                        b_q     <= b_ext;
                        neg_q   <= negate_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_q + pp;
                    a_q   <= a_q >> RB;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state_q <= neg_q ? StNeg : StDone;
                    end
                end
                StNeg: begin
                    acc_q   <= ~acc_q + PW'(1);
                    state_q <= StDone;
                end
                StDone: begin
                    if (ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o = (state_q == StIdle);
    assign valid_o = (state_q == StDone);
    assign prod_o  = acc_q;

endmodule

// File: tb/tb_hwpe_ctrl_seq_mult_radix.sv
// Directed bench for hwpe_ctrl_seq_mult_radix: RB=2 and RB=3 instances, scoreboard of products.
module tb_hwpe_ctrl_seq_mult_radix;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        start0;
    logic        start1;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic        neg;
    logic        rdy;
    logic        ready0;
    logic        valid0;
    logic [15:0] prod0;
    logic        ready1;
    logic        valid1;
    logic [15:0] prod1;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    hwpe_ctrl_seq_mult_radix #(
        .AW(8),
        .BW(8),
        .RB(2)
    ) u_dut0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr),
        .start_i (start0),
        .ready_o (ready0),
        .a_i     (a),
        .b_i     (b),
        .signed_i(sgn),
        .negate_i(neg),
        .valid_o (valid0),
        .ready_i (rdy),
        .prod_o  (prod0)
    );

    hwpe_ctrl_seq_mult_radix #(
        .AW(8),
        .BW(8),
        .RB(3)
    ) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clr),
        .start_i (start1),
        .ready_o (ready1),
        .a_i     (a),
        .b_i     (b),
        .signed_i(sgn),
        .negate_i(neg),
        .valid_o (valid1),
        .ready_i (rdy),
        .prod_o  (prod1)
    );

    function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv,
                                          input logic sv, input logic nv);
        longint x;
        longint y;
        longint p;
        logic   se;
        logic [15:0] r;
`ifdef HWPE_CTRL_SEQ_MULT_SIGNED_EN
        se = sv;
`else
        se = 1'b0 & sv;
`endif
        x = se ? longint'($signed(av)) : longint'(av);
        y = se ? longint'($signed(bv)) : longint'(bv);
        p = x * y;
        if (nv) p = -p;
        r = p[15:0];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; bp holds off the consumer for 3 DONE cycles and pokes start_i.
    task automatic run_op(input string tag, input bit sel, input logic [7:0] av,
                          input logic [7:0] bv, input logic sv, input logic nv,
                          input int exp_lat, input bit bp);
        int lat;
        logic [15:0] exp_p;
        check({tag, "_ready_before"}, 32'(sel ? ready1 : ready0), 32'd1);
        a   = av;
        b   = bv;
        sgn = sv;
        neg = nv;
        rdy = !bp;
        if (sel) start1 = 1'b1;
        else start0 = 1'b1;
        sb_q.push_back(model(av, bv, sv, nv));
        tick();
        lat = 1;
        if (bp) begin
            a = ~av;
            b = ~bv;
        end else begin
            start0 = 1'b0;
            start1 = 1'b0;
        end
        while (!(sel ? valid1 : valid0) && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        exp_p = (sb_q.size() != 0) ? sb_q[0] : 16'hxxxx;
        if (bp) begin
            for (int i = 0; i < 3; i++) begin
                check({tag, "_bp_prod"}, 32'(sel ? prod1 : prod0), 32'(exp_p));
                check({tag, "_bp_ready"}, 32'(sel ? ready1 : ready0), 32'd0);
                check({tag, "_bp_valid"}, 32'(sel ? valid1 : valid0), 32'd1);
                tick();
            end
            start0 = 1'b0;
            start1 = 1'b0;
            rdy    = 1'b1;
        end
        check({tag, "_prod"}, 32'(sel ? prod1 : prod0), 32'(exp_p));
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        tick();
        check({tag, "_valid_after"}, 32'(sel ? valid1 : valid0), 32'd0);
        check({tag, "_ready_after"}, 32'(sel ? ready1 : ready0), 32'd1);
        check({tag, "_prod_hold"}, 32'(sel ? prod1 : prod0), 32'(exp_p));
        if (bp) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check({tag, "_no_second"}, 32'(sel ? valid1 : valid0), 32'd0);
            end
        end
        a   = '0;
        b   = '0;
        sgn = 1'b0;
        neg = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        a      = '0;
        b      = '0;
        sgn    = 1'b0;
        neg    = 1'b0;
        rdy    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_valid0", 32'(valid0), 32'd0);
        check("rst_prod0", 32'(prod0), 32'd0);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_valid1", 32'(valid1), 32'd0);
        check("rst_prod1", 32'(prod1), 32'd0);

        run_op("u_200x150", 1'b0, 8'd200, 8'd150, 1'b0, 1'b0, 5, 1'b0);
        run_op("s_m3x5", 1'b0, 8'hFD, 8'h05, 1'b1, 1'b0, 5, 1'b0);
        run_op("neg_3x4", 1'b0, 8'd3, 8'd4, 1'b0, 1'b1, 6, 1'b0);
        run_op("bp_17x9", 1'b0, 8'd17, 8'd9, 1'b0, 1'b0, 5, 1'b1);

        // Abort in the second RUN cycle; no result may surface.
        a      = 8'd200;
        b      = 8'd150;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ready", 32'(ready0), 32'd1);
        check("clr_valid", 32'(valid0), 32'd0);
        check("clr_prod", 32'(prod0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("clr_no_result", 32'(valid0), 32'd0);
        end

        run_op("after_clr", 1'b0, 8'd200, 8'd150, 1'b0, 1'b0, 5, 1'b0);
        run_op("s_neg_m128x127", 1'b0, 8'h80, 8'h7F, 1'b1, 1'b1, 6, 1'b0);
        run_op("r3_255x255", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 4, 1'b0);
        run_op("r3_s_m128xm128", 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 4, 1'b0);
        run_op("r3_s_m1x127", 1'b1, 8'hFF, 8'h7F, 1'b1, 1'b0, 4, 1'b0);
        run_op("r3_neg_7x9", 1'b1, 8'd7, 8'd9, 1'b0, 1'b1, 5, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_seq_mult_radix.md
# hwpe_ctrl_seq_mult_radix

Parametrised sequential multiplier for HWPE controllers. Consumes RB multiplier bits per cycle, so latency is ceil(AW/RB) cycles instead of AW. Latches both operands on acceptance, so callers need not hold inputs stable. Supports signed operands, optional result negation and valid/ready handshakes on both sides. Used by controller micro-code and address generators to compute strides and loop bounds.

## Interface
- AW, default 8: width of multiplier operand a_i.
- BW, default 8: width of multiplicand operand b_i.
- RB, default 2: multiplier bits consumed per cycle; 1 ≤ RB ≤ AW.
- Derived constant N = ceil(AW/RB): number of iterations.
- Derived constant PW = AW+BW: product width.
- clk_i  in  1  clock; the block uses this single clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  request valid; accepted when start_i && ready_o.
- ready_o  out  1  block can accept a request.
- a_i  in  AW  multiplier operand.
- b_i  in  BW  multiplicand operand.
- signed_i  in  1  treat a_i and b_i as two's complement.
- negate_i  in  1  output −(a·b) instead of a·b.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- prod_o  out  PW  product.

## Operation
- FSM states: IDLE, RUN, NEG, DONE.
- Operand latching on accept:
  - a_i is extended to N·RB bits: sign-extended if signed, zero-extended otherwise.
  - b_i is extended to PW bits the same way.
  - signed_i and negate_i are latched.
  - Accumulator is set to 0, cnt is set to 0, and the FSM goes IDLE→RUN.
- Each RUN cycle:
  - Takes chunk k = a[k·RB +: RB].
  - Adds (chunk·b_ext) << (k·RB) to the accumulator, modulo 2^PW.
  - The chunk is unsigned, except that the last chunk (k = N−1) is interpreted as a signed RB-bit value when signed mode is set.
- RUN exit: at k = N−1, go to NEG if negate is latched, else go to DONE.
- NEG: one cycle; acc ← ~acc + 1, then go to DONE.
- DONE: valid_o = 1. When ready_i = 1, go to IDLE.
- ready_o = (state == IDLE). It is driven combinationally from the state register.
- prod_o = accumulator register.
  - Holds its value after the handshake until the next accept.
  - Is exact for all operand values in both modes, since |a·b| fits in PW bits.
- start_i is ignored while ready_o = 0.
- rst_i and clear_i:
  - Have priority over everything.
  - Give state = IDLE, prod_o = 0, valid_o = 0, ready_o = 1.
  - Asserted mid-operation, they abort the operation with no result produced.

## Timing
- Reset values: ready_o = 1, valid_o = 0, prod_o = 0.
- Accept edge at cycle 0; RUN occupies cycles 1..N.
- valid_o rises in cycle N+1 without negate, N+2 with negate.
- valid_o and prod_o stay stable while ready_i = 0.
- If ready_i = 1 in the first DONE cycle, valid_o lasts one cycle and ready_o returns the following cycle.
- Minimum request period: N+2 cycles, or N+3 with negate.
- No combinational path from start_i/a_i/b_i or ready_i to any output. ready_o and valid_o depend on the state register only.

## Configuration
- Macro HWPE_CTRL_SEQ_MULT_SIGNED_EN.
- Defined: signed_i is honoured as described above.
- Undefined:
  - signed_i is ignored and treated as 0.
  - All extension is zero-extension and the last chunk is unsigned.
  - The sign-handling logic is removed.

## Structure
- hwpe_ctrl_package holds the state typedef hwpe_ctrl_seq_mult_state_t (IDLE/RUN/NEG/DONE).
- hwpe_ctrl_package also holds helper function hwpe_ctrl_seq_mult_iter(AW, RB), which returns N.
- Sub-module hwpe_ctrl_seq_mult_pp: purely combinational partial-product generator. Inputs: chunk, b_ext, k, last flag, signed flag. Output: the shifted PW-bit partial product.

## Test plan
- AW=BW=8, RB=2, unsigned, a=200, b=150 → prod_o=0x7530; valid_o rises in cycle 5.
- Signed, a=0xFD (−3), b=0x05 → prod_o=0xFFF1 (−15). With the macro undefined → prod_o=0x04F1.
- negate_i=1, unsigned, a=3, b=4 → prod_o=0xFFF4; valid_o rises in cycle 6.
- Backpressure: hold ready_i=0 for 3 DONE cycles → prod_o stable and ready_o=0. start_i pulses during RUN and DONE are ignored, and no second result appears.
- clear_i asserted in RUN cycle 2 → next cycle state IDLE, prod_o=0, valid_o=0, ready_o=1. A new request afterwards completes correctly.
- RB=3, AW=8 (N=3, padded chunk):
  - 255×255 → 0xFE01 at cycle 4.
  - Signed −128×−128 → 0x4000.
  - Signed −1×127 → 0xFF81.
